// File: rtl/mac_dot_acc_pkg.sv
// Shared types and the accumulate step for mac_dot_acc.
// Optional build macro: MAC_DOT_ACC_SATURATE_EN (saturating instead of wrapping accumulate).
package mac_dot_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_e;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef struct packed {
    logic [63:0] acc;
    logic        carry;
  } acc_res_t;

  // Works in a 64-bit container so one function serves any ACC_W in 32..64.
  function automatic acc_res_t acc_step(input logic [63:0]       base,
                                        input logic [PROD_W-1:0] r,
                                        input int unsigned       acc_w);
    logic [64:0] sum;
    logic [64:0] mask;
    acc_res_t    res;
    sum  = {1'b0, base} + {33'd0, r};
    mask = (65'd1 << acc_w) - 65'd1;
    // base < 2^acc_w and r < 2^acc_w, so bit acc_w is the only possible spill.
    res.carry = |(sum & ~mask);
`ifdef MAC_DOT_ACC_SATURATE_EN
    res.acc = res.carry ? mask[63:0] : (sum[63:0] & mask[63:0]);
`else
    res.acc = sum[63:0] & mask[63:0];
`endif
    return res;
  endfunction

endpackage

// File: rtl/mac_dot_acc_if.sv
// Operand-beat input stream and accumulated-result output stream of mac_dot_acc.
interface mac_dot_acc_if #(
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [15:0]      in_c;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mac_dot_acc.sv
// Dot-product accumulator around an external combinational mac (R = A*B + C).
// Build macro MAC_DOT_ACC_SATURATE_EN selects saturating accumulate (see package).
module mac_dot_acc
  import mac_dot_acc_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 40,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  mac_dot_acc_if.slave      bus,
  output logic [OP_W-1:0]   mac_a,
  output logic [OP_W-1:0]   mac_b,
  output logic [OP_W-1:0]   mac_c,
  input  logic [PROD_W-1:0] mac_r
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic [OP_W-1:0]   mac_a_q, mac_a_d, mac_b_q, mac_b_d, mac_c_q, mac_c_d;
  logic              vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
  logic [PROD_W-1:0] r_p2_q, r_p2_d;
  logic              vld_p2_q, vld_p2_d, first_p2_q, first_p2_d, last_p2_q, last_p2_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic              xfer;
  logic              beat_last;
  acc_res_t          acc_res;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_c_d     = mac_c_q;
    first_p1_d  = first_p1_q;
    last_p1_d   = last_p1_q;
    r_p2_d      = r_p2_q;
    first_p2_d  = first_p2_q;
    last_p2_d   = last_p2_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    xfer      = bus.in_valid && in_ready_q;
    beat_last = (cnt_q == LAST_CNT);

    // Stage 1: capture the beat onto the mac operand ports
    vld_p1_d = xfer;
    if (xfer) begin
      mac_a_d    = bus.in_a;
      mac_b_d    = bus.in_b;
      mac_c_d    = bus.in_c;
      first_p1_d = (cnt_q == '0);
      last_p1_d  = beat_last;
      cnt_d      = beat_last ? '0 : cnt_q + CNT_W'(1);
    end

    // Stage 2: register the mac result
    vld_p2_d = vld_p1_q;
    if (vld_p1_q) begin
      r_p2_d     = mac_r;
      first_p2_d = first_p1_q;
      last_p2_d  = last_p1_q;
    end

    // Stage 3: accumulate and publish the vector result
    acc_res = acc_step(first_p2_q ? 64'd0 : 64'(acc_q), r_p2_q, ACC_W);
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (vld_p2_q) begin
      acc_d = acc_res.acc[ACC_W-1:0];
      ovf_d = (first_p2_q ? 1'b0 : ovf_q) | acc_res.carry;
      if (last_p2_q) begin
        out_data_d  = acc_d;
        out_ovf_d   = ovf_d;
        out_valid_d = 1'b1;
      end
    end

    case (state_q)
      IDLE:    if (xfer) state_d = beat_last ? DRAIN : ACCUM;
      ACCUM:   if (xfer && beat_last) state_d = DRAIN;
      DRAIN:   if (vld_p2_q && last_p2_q) state_d = HOLD;
      HOLD:    if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
      vld_p1_q    <= 1'b0;
      first_p1_q  <= 1'b0;
      last_p1_q   <= 1'b0;
      r_p2_q      <= '0;
      vld_p2_q    <= 1'b0;
      first_p2_q  <= 1'b0;
      last_p2_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
      vld_p1_q    <= vld_p1_d;
      first_p1_q  <= first_p1_d;
      last_p1_q   <= last_p1_d;
      r_p2_q      <= r_p2_d;
      vld_p2_q    <= vld_p2_d;
      first_p2_q  <= first_p2_d;
      last_p2_q   <= last_p2_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign mac_a         = mac_a_q;
  assign mac_b         = mac_b_q;
  assign mac_c         = mac_c_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_dot_acc.sv
// Directed bench for mac_dot_acc: VEC_LEN=4/ACC_W=33 and VEC_LEN=1/ACC_W=40 instances.
module tb_mac_dot_acc;

  logic clk;
  logic rst;
  logic ovr;
  int   n_cmp;
  int   n_err;

  logic [15:0] mac_a4, mac_b4, mac_c4, mac_a1, mac_b1, mac_c1;
  logic [31:0] mac_r4, mac_r1;

  mac_dot_acc_if #(.ACC_W(33)) if4 ();
  mac_dot_acc_if #(.ACC_W(40)) if1 ();

  mac_dot_acc #(.VEC_LEN(4), .ACC_W(33), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .bus(if4),
    .mac_a(mac_a4), .mac_b(mac_b4), .mac_c(mac_c4), .mac_r(mac_r4)
  );

  mac_dot_acc #(.VEC_LEN(1), .ACC_W(40), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .bus(if1),
    .mac_a(mac_a1), .mac_b(mac_b1), .mac_c(mac_c1), .mac_r(mac_r1)
  );

  // Exact mac model; ovr forces an all-ones product that real operands cannot reach.
  assign mac_r4 = ovr ? 32'hFFFF_FFFF : (32'(mac_a4) * 32'(mac_b4) + 32'(mac_c4));
  assign mac_r1 = 32'(mac_a1) * 32'(mac_b1) + 32'(mac_c1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0][15:0] c;
    logic             gaps;
    logic             ovr;
    logic [63:0]      exp_data;
    logic             exp_ovf;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int k);
    int n;
    int lat;
    int irl;
    ovr = tbl[k].ovr;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!if4.in_ready && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) chk($sformatf("v%0d_ready_timeout", k), 64'(n), 64'd0);
      if4.in_valid = 1'b1;
      if4.in_a     = tbl[k].a[i];
      if4.in_b     = tbl[k].b[i];
      if4.in_c     = tbl[k].c[i];
      step();
      if4.in_valid = 1'b0;
      if4.in_a     = 16'hDEAD;
      if (tbl[k].gaps && i < 3) begin
        step();
        chk($sformatf("v%0d_bubble_a%0d", k, i), 64'(mac_a4), 64'(tbl[k].a[i]));
        chk($sformatf("v%0d_bubble_b%0d", k, i), 64'(mac_b4), 64'(tbl[k].b[i]));
      end
    end
    lat = 0;
    irl = 0;
    while (!if4.out_valid && lat < 20) begin
      if (!if4.in_ready) irl++;
      step();
      lat++;
    end
    if (!if4.in_ready) irl++;
    chk($sformatf("v%0d_latency", k), 64'(lat), 64'd2);
    chk($sformatf("v%0d_ready_low", k), 64'(irl), 64'd3);
    chk($sformatf("v%0d_data", k), 64'(if4.out_data), tbl[k].exp_data);
    chk($sformatf("v%0d_ovf", k), 64'(if4.out_ovf), 64'(tbl[k].exp_ovf));
    step();
    chk($sformatf("v%0d_valid_drop", k), 64'(if4.out_valid), 64'd0);
    chk($sformatf("v%0d_ready_back", k), 64'(if4.in_ready), 64'd1);
    ovr = 1'b0;
  endtask

  initial begin : main
    int n;
    int got;
    logic xfer1;
    logic [39:0] exp1 [2];

    n_cmp = 0;
    n_err = 0;
    ovr   = 1'b0;
    rst   = 1'b1;
    if4.in_valid = 1'b0; if4.in_a = '0; if4.in_b = '0; if4.in_c = '0; if4.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.in_c = '0; if1.out_ready = 1'b1;

    tbl[0].a = {4{16'd2}}; tbl[0].b = {4{16'd3}}; tbl[0].c = {4{16'd1}};
    tbl[0].gaps = 1'b0; tbl[0].ovr = 1'b0; tbl[0].exp_data = 64'd28; tbl[0].exp_ovf = 1'b0;
    tbl[1].a = {16'd4, 16'd3, 16'd2, 16'd1}; tbl[1].b = {16'd4, 16'd3, 16'd2, 16'd1};
    tbl[1].c = {4{16'd0}};
    tbl[1].gaps = 1'b1; tbl[1].ovr = 1'b0; tbl[1].exp_data = 64'd30; tbl[1].exp_ovf = 1'b0;
    tbl[2].a = {4{16'hFFFF}}; tbl[2].b = {4{16'hFFFF}}; tbl[2].c = {4{16'hFFFE}};
    tbl[2].gaps = 1'b0; tbl[2].ovr = 1'b1; tbl[2].exp_ovf = 1'b1;
`ifdef MAC_DOT_ACC_SATURATE_EN
    tbl[2].exp_data = 64'h1_FFFF_FFFF;
`else
    tbl[2].exp_data = 64'h1_FFFF_FFFC;
`endif
    tbl[3].a = {4{16'd0}}; tbl[3].b = {4{16'd0}}; tbl[3].c = {4{16'd5}};
    tbl[3].gaps = 1'b0; tbl[3].ovr = 1'b0; tbl[3].exp_data = 64'd20; tbl[3].exp_ovf = 1'b0;
    tbl[4].a = {4{16'd1}}; tbl[4].b = {4{16'd1}}; tbl[4].c = {4{16'd1}};
    tbl[4].gaps = 1'b0; tbl[4].ovr = 1'b0; tbl[4].exp_data = 64'd8; tbl[4].exp_ovf = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rst_in_ready", 64'(if4.in_ready), 64'd1);
    chk("rst_out_valid", 64'(if4.out_valid), 64'd0);
    chk("rst_out_data", 64'(if4.out_data), 64'd0);
    chk("rst_out_ovf", 64'(if4.out_ovf), 64'd0);
    chk("rst_mac_abc", 64'({mac_a4, mac_b4, mac_c4}), 64'd0);
    chk("rst_u1_valid", 64'(if1.out_valid), 64'd0);

    for (int k = 0; k < 4; k++) run_vec(k);

    // Backpressure: result held for 5 cycles, in_valid ignored in DRAIN/HOLD
    if4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if4.in_valid = 1'b1; if4.in_a = 16'd2; if4.in_b = 16'd3; if4.in_c = 16'd1;
      step();
    end
    if4.in_a = 16'd9; if4.in_b = 16'd9; if4.in_c = 16'd9;
    n = 0;
    while (!if4.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("hold_latency", 64'(n), 64'd2);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_valid%0d", i), 64'(if4.out_valid), 64'd1);
      chk($sformatf("hold_data%0d", i), 64'(if4.out_data), 64'd28);
      chk($sformatf("hold_ready%0d", i), 64'(if4.in_ready), 64'd0);
      chk($sformatf("hold_mac_a%0d", i), 64'(mac_a4), 64'd2);
      step();
    end
    if4.out_ready = 1'b1;
    chk("hold_valid_last", 64'(if4.out_valid), 64'd1);
    step();
    chk("hold_valid_drop", 64'(if4.out_valid), 64'd0);
    chk("hold_ready_back", 64'(if4.in_ready), 64'd1);
    chk("hold_no_accept", 64'(mac_a4), 64'd2);
    if4.in_valid = 1'b0;
    step();

    // Reset mid-vector discards the partial sum
    for (int i = 0; i < 2; i++) begin
      if4.in_valid = 1'b1; if4.in_a = 16'd5; if4.in_b = 16'd5; if4.in_c = 16'd5;
      step();
    end
    if4.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("abort_async_mac", 64'(mac_a4), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("abort_no_out", 64'(if4.out_valid), 64'd0);
    run_vec(4);

    // VEC_LEN=1: one result per beat
    exp1[0] = 40'd44;
    exp1[1] = 40'd2;
    chk("v1_ready_start", 64'(if1.in_ready), 64'd1);
    if1.in_valid = 1'b1; if1.in_a = 16'd7; if1.in_b = 16'd6; if1.in_c = 16'd2;
    step();
    chk("v1_ready_drop", 64'(if1.in_ready), 64'd0);
    if1.in_a = 16'd1; if1.in_b = 16'd1; if1.in_c = 16'd1;
    got = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (if1.out_valid) begin
        if (got < 2) chk($sformatf("v1_out%0d", got), 64'(if1.out_data), 64'(exp1[got]));
        got++;
      end
      xfer1 = if1.in_valid && if1.in_ready;
      step();
      if (xfer1) if1.in_valid = 1'b0;
    end
    chk("v1_out_count", 64'(got), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
